// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package imem_fetch_pkg;

    typedef enum logic [1:0] {
        FS_RUN    = 2'd0,
        FS_HALTED = 2'd1,
        FS_FAULT  = 2'd2
    } fetch_state_e;

    localparam int          INST_BYTES = 4;
    localparam logic [31:0] NOP_INST   = 32'h00000013;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Memory, redirect/halt and decode-side handshake bundle of the fetch controller.
interface imem_fetch_ctrl_if #(
    parameter int ADDR_W = 64
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              fault;

    modport master (
        output imem_addr, out_valid, out_inst, out_pc, fault,
        input  imem_rdata, redirect_valid, redirect_pc, halt, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_inst, out_pc, fault,
        output imem_rdata, redirect_valid, redirect_pc, halt, out_ready
    );
endinterface

// File: rtl/imem_fetch_fifo.sv
// Prefetch FIFO holding {pc, inst} entries; head output is presented combinationally
// from storage, and the last shown head is held once the FIFO goes empty.
module imem_fetch_fifo
    import imem_fetch_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 2,
    localparam int W     = ADDR_W + 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [W-1:0]     wdata_i,
    output logic [W-1:0]     rdata_o,
    output logic             full_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [W-1:0] RST_ENTRY = {{ADDR_W{1'b0}}, NOP_INST};

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0]   cnt_q;
    logic [W-1:0]     last_q;
    logic             empty;
    logic             do_pop;

    assign empty   = (cnt_q == '0);
    assign do_pop  = pop_i && !empty;
    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = empty ? last_q : mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_ENTRY;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            // Remember whatever head was visible so the outputs stay put when empty.
            if ((flush_i || pop_i) && !empty) last_q <= mem_q[rd_q];
            if (flush_i) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push_i) begin
                    mem_q[wr_q] <= wdata_i;
                    wr_q        <= wr_q + 1'b1;
                end
                if (do_pop) rd_q <= rd_q + 1'b1;
                cnt_q <= cnt_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(do_pop);
            end
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, fills the prefetch FIFO, handles redirect/halt/fault.
// Optional IMEM_FETCH_PERF_EN adds saturating fetch and stall counters.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter int                ADDR_W     = 64,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                MEM_BYTES  = 72,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    imem_fetch_ctrl_if.master bus
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic              push, flush, pop, space;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;

    // Range check is widened by one bit so a wrapped pc+3 can never look legal.
    function automatic logic fetch_ok(input logic [ADDR_W-1:0] pc);
        logic [ADDR_W:0] last_byte;
        last_byte = {1'b0, pc} + (ADDR_W+1)'(INST_BYTES - 1);
        return (pc[1:0] == 2'b00) && (last_byte < (ADDR_W+1)'(MEM_BYTES));
    endfunction

    assign bus.imem_addr = fpc_q;
    assign bus.out_valid = (fifo_count != '0);
    assign bus.fault     = (state_q == FS_FAULT);
    assign pop           = bus.out_valid && bus.out_ready;
    assign space         = !fifo_full || pop;

    imem_fetch_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i ({fpc_q, bus.imem_rdata}),
        .rdata_o ({bus.out_pc, bus.out_inst}),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FS_RUN;
            fpc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (bus.redirect_valid) begin
            flush = 1'b1;
            if (fetch_ok(bus.redirect_pc)) begin
                fpc_d   = bus.redirect_pc;
                state_d = FS_RUN;
            end else begin
                state_d = FS_FAULT;
            end
        end else begin
            case (state_q)
                FS_RUN: begin
                    if (!fetch_ok(fpc_q)) begin
                        state_d = FS_FAULT;
                    end else if (bus.halt) begin
                        state_d = FS_HALTED;
                    end else if (space) begin
                        push  = 1'b1;
                        fpc_d = fpc_q + ADDR_W'(INST_BYTES);
                    end
                end
                FS_HALTED: if (!bus.halt) state_d = FS_RUN;
                default: ;
            endcase
        end
    end

`ifdef IMEM_FETCH_PERF_EN
    logic        stall;
    logic [31:0] perf_fetched_q, perf_stall_q;

    assign stall = (state_q == FS_RUN) && !bus.redirect_valid && fetch_ok(fpc_q)
                   && !bus.halt && fifo_full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push && !(&perf_fetched_q)) perf_fetched_q <= perf_fetched_q + 32'd1;
            if (stall && !(&perf_stall_q))  perf_stall_q   <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
